gsensor_spi_slave: RTL and testbench

GSENSOR_SPI_SLAVE -- requirements
Module: gsensor_spi_slave

---
 rtl/gsensor_spi_pkg.sv | 29 ++
 rtl/spi_sync_edge.sv | 35 +++
 rtl/gsensor_spi_slave.sv | 164 ++++++++++++++++
 tb/tb_gsensor_spi_slave.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/gsensor_spi_pkg.sv
// Shared constants and types for the G-sensor SPI slave.
package gsensor_spi_pkg;

    // Register map
    localparam logic [5:0] AddrDevid  = 6'h00;
    localparam logic [5:0] AddrDataX0 = 6'h32;
    localparam logic [5:0] AddrDataX1 = 6'h33;
    localparam logic [5:0] AddrDataY0 = 6'h34;
    localparam logic [5:0] AddrDataY1 = 6'h35;
    localparam logic [5:0] AddrDataZ0 = 6'h36;
    localparam logic [5:0] AddrDataZ1 = 6'h37;

    // Command byte layout: R/nW, multi-byte, start address
    localparam int unsigned CmdRnwBit  = 7;
    localparam int unsigned CmdMbBit   = 6;
    localparam int unsigned CmdAddrMsb = 5;

    typedef enum logic [1:0] {
        StIdle,
        StCmd,
        StData
    } spi_state_e;

    // Device ID and sample registers cannot be written over SPI.
    function automatic logic is_read_only(input logic [5:0] addr);
        return (addr == AddrDevid) || ((addr >= AddrDataX0) && (addr <= AddrDataZ1));
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-stage synchronizer with rise/fall detection on the synchronized value.
module spi_sync_edge #(
    parameter int unsigned STAGES    = 2,
    parameter logic        RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    // Shift the pin through the synchronizer and remember the last synced value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {STAGES{RESET_VAL}};
            prev_q <= RESET_VAL;
        end else begin
            sync_q[0] <= din;
            for (int i = 1; i < int'(STAGES); i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign dout = sync_q[STAGES-1];
    assign rise = dout & ~prev_q;
    assign fall = ~dout & prev_q;

endmodule

// File: rtl/gsensor_spi_slave.sv
// SPI mode-3 register slave for a 3-axis G-sensor, oversampled on clk_clk.
module gsensor_spi_slave
    import gsensor_spi_pkg::*;
#(
    parameter logic [7:0]  DEVID       = 8'hE5,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        clk_clk,
    input  logic        reset_reset_n,
    input  logic        spi_cs_n,
    input  logic        spi_sclk,
    input  logic        spi_sdi,
    output logic        spi_sdo,
    output logic        spi_sdo_oe,
    input  logic [15:0] smp_x,
    input  logic [15:0] smp_y,
    input  logic [15:0] smp_z,
    input  logic        smp_valid,
    output logic        reg_wr,
    output logic [5:0]  reg_wr_addr,
    output logic [7:0]  reg_wr_data
);

    spi_state_e  state_q, state_d;
    logic        cs_n_s, cs_rise, cs_fall;
    logic        sclk_s, sclk_rise, sclk_fall;
    logic        sdi_s, sdi_rise, sdi_fall;
    logic        unused_sync;
    logic [2:0]  bit_cnt_q;
    logic [6:0]  rx_q;
    logic [7:0]  rx_byte, tx_q, rd_data;
    logic        rnw_q, mb_q;
    logic [5:0]  addr_q;
    logic [7:0]  regs_q [64];
    logic        pend_valid_q;
    logic [15:0] pend_x_q, pend_y_q, pend_z_q;
    logic [15:0] src_x, src_y, src_z;
    logic        byte_done, apply_new, apply_pend;

    // cs_n chain resets low so a pin held low across reset never looks like a fresh fall.
    spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_cs (
        .clk(clk_clk), .rst_n(reset_reset_n), .din(spi_cs_n),
        .dout(cs_n_s), .rise(cs_rise), .fall(cs_fall)
    );
    spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_sclk (
        .clk(clk_clk), .rst_n(reset_reset_n), .din(spi_sclk),
        .dout(sclk_s), .rise(sclk_rise), .fall(sclk_fall)
    );
    spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sdi (
        .clk(clk_clk), .rst_n(reset_reset_n), .din(spi_sdi),
        .dout(sdi_s), .rise(sdi_rise), .fall(sdi_fall)
    );

    assign unused_sync = ^{cs_n_s, sclk_s, sdi_rise, sdi_fall};

    assign rx_byte    = {rx_q, sdi_s};
    assign byte_done  = sclk_rise && (bit_cnt_q == 3'd7);
    assign rd_data    = (addr_q == AddrDevid) ? DEVID : regs_q[addr_q];
    // A sample arriving with cs_n rise is newer than anything pending, so it wins.
    assign apply_new  = smp_valid && ((state_q == StIdle) || cs_rise);
    assign apply_pend = cs_rise && pend_valid_q && !smp_valid;
    assign src_x      = apply_new ? smp_x : pend_x_q;
    assign src_y      = apply_new ? smp_y : pend_y_q;
    assign src_z      = apply_new ? smp_z : pend_z_q;

    // FSM state register.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) state_q <= StIdle;
        else                state_q <= state_d;
    end

    // FSM next state: cs_n rise always wins.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (cs_fall) state_d = StCmd;
            StCmd:   if (cs_rise) state_d = StIdle;
                     else if (byte_done) state_d = StData;
            StData:  if (cs_rise) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Shift engine, register file, sample capture and write strobe.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            bit_cnt_q    <= '0;
            rx_q         <= '0;
            tx_q         <= '0;
            rnw_q        <= 1'b0;
            mb_q         <= 1'b0;
            addr_q       <= '0;
            spi_sdo      <= 1'b0;
            spi_sdo_oe   <= 1'b0;
            reg_wr       <= 1'b0;
            reg_wr_addr  <= '0;
            reg_wr_data  <= '0;
            pend_valid_q <= 1'b0;
            pend_x_q     <= '0;
            pend_y_q     <= '0;
            pend_z_q     <= '0;
            for (int i = 0; i < 64; i++) regs_q[i] <= '0;
        end else begin
            reg_wr <= 1'b0;

            if (apply_new || apply_pend) begin
                regs_q[AddrDataX0] <= src_x[7:0];
                regs_q[AddrDataX1] <= src_x[15:8];
                regs_q[AddrDataY0] <= src_y[7:0];
                regs_q[AddrDataY1] <= src_y[15:8];
                regs_q[AddrDataZ0] <= src_z[7:0];
                regs_q[AddrDataZ1] <= src_z[15:8];
            end
            if (smp_valid && !apply_new) begin
                pend_valid_q <= 1'b1;
                pend_x_q     <= smp_x;
                pend_y_q     <= smp_y;
                pend_z_q     <= smp_z;
            end else if (cs_rise) begin
                pend_valid_q <= 1'b0;
            end

            if (cs_rise) begin
                spi_sdo_oe <= 1'b0;
                spi_sdo    <= 1'b0;
            end

            if ((state_q == StIdle) && cs_fall) bit_cnt_q <= '0;

            if ((state_q != StIdle) && !cs_rise) begin
                if (sclk_rise) begin
                    rx_q      <= rx_byte[6:0];
                    bit_cnt_q <= bit_cnt_q + 3'd1;
                end
                if (byte_done && (state_q == StCmd)) begin
                    rnw_q  <= rx_byte[CmdRnwBit];
                    mb_q   <= rx_byte[CmdMbBit];
                    addr_q <= rx_byte[CmdAddrMsb:0];
                end
                if (byte_done && (state_q == StData)) begin
                    if (!rnw_q && !is_read_only(addr_q)) begin
                        regs_q[addr_q] <= rx_byte;
                        reg_wr         <= 1'b1;
                        reg_wr_addr    <= addr_q;
                        reg_wr_data    <= rx_byte;
                    end
                    if (mb_q) addr_q <= addr_q + 6'd1;
                end
                // Reads: first fall of each byte fetches the register, later falls shift.
                if (sclk_fall && (state_q == StData) && rnw_q) begin
                    spi_sdo_oe <= 1'b1;
                    if (bit_cnt_q == 3'd0) begin
                        spi_sdo <= rd_data[7];
                        tx_q    <= {rd_data[6:0], 1'b0};
                    end else begin
                        spi_sdo <= tx_q[7];
                        tx_q    <= {tx_q[6:0], 1'b0};
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_gsensor_spi_slave.sv
// Directed bench for gsensor_spi_slave with read/write scoreboards.
module tb_gsensor_spi_slave;

    localparam int HALF = 8;  // clk_clk cycles per half sclk period

    logic        clk_clk = 1'b0;
    logic        reset_reset_n = 1'b0;
    logic        spi_cs_n = 1'b1;
    logic        spi_sclk = 1'b1;
    logic        spi_sdi = 1'b0;
    logic        spi_sdo, spi_sdo_oe;
    logic [15:0] smp_x = '0, smp_y = '0, smp_z = '0;
    logic        smp_valid = 1'b0;
    logic        reg_wr;
    logic [5:0]  reg_wr_addr;
    logic [7:0]  reg_wr_data;

    int          n_cmp = 0;
    int          n_fail = 0;
    logic [7:0]  exp_rd[$];
    logic [13:0] exp_wr[$];
    logic [13:0] wr_log[$];

    always #5 clk_clk = ~clk_clk;

    gsensor_spi_slave #(.DEVID(8'hE5), .SYNC_STAGES(2)) dut (
        .clk_clk(clk_clk), .reset_reset_n(reset_reset_n),
        .spi_cs_n(spi_cs_n), .spi_sclk(spi_sclk), .spi_sdi(spi_sdi),
        .spi_sdo(spi_sdo), .spi_sdo_oe(spi_sdo_oe),
        .smp_x(smp_x), .smp_y(smp_y), .smp_z(smp_z), .smp_valid(smp_valid),
        .reg_wr(reg_wr), .reg_wr_addr(reg_wr_addr), .reg_wr_data(reg_wr_data)
    );

    // Every cycle reg_wr is high logs one write event.
    always @(negedge clk_clk) begin
        if (reg_wr) wr_log.push_back({reg_wr_addr, reg_wr_data});
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Mode-3 master: drive sdi on the fall, sample sdo just before the rise.
    task automatic xfer_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx,
                             output logic oe_any, output logic oe_all);
        rx = '0;
        oe_any = 1'b0;
        oe_all = 1'b1;
        for (int i = 7; i >= 8 - nbits; i--) begin
            spi_sclk = 1'b0;
            spi_sdi  = tx[i];
            tick(HALF);
            rx[i]  = spi_sdo;
            oe_any = oe_any | spi_sdo_oe;
            oe_all = oe_all & spi_sdo_oe;
            spi_sclk = 1'b1;
            tick(HALF);
        end
    endtask

    task automatic cs_begin();
        spi_cs_n = 1'b0;
        tick(HALF);
    endtask

    task automatic cs_end();
        spi_cs_n = 1'b1;
        tick(2 * HALF);
    endtask

    task automatic send_cmd(input string tag, input logic [7:0] cmd);
        logic [7:0] rx;
        logic oe_any, oe_all;
        xfer_bits(cmd, 8, rx, oe_any, oe_all);
        check({tag, "_cmd_oe"}, 16'(oe_any), 16'h0);
    endtask

    // Reads n bytes, comparing each against the front of exp_rd.
    task automatic read_burst(input string tag, input logic [7:0] cmd, input int n);
        logic [7:0] rx;
        logic oe_any, oe_all;
        cs_begin();
        send_cmd(tag, cmd);
        for (int b = 0; b < n; b++) begin
            xfer_bits(8'h00, 8, rx, oe_any, oe_all);
            check($sformatf("%s_b%0d", tag, b), 16'(rx), 16'(exp_rd.pop_front()));
            check($sformatf("%s_b%0d_oe", tag, b), 16'(oe_all), 16'h1);
        end
        cs_end();
        check({tag, "_oe_after_cs"}, 16'(spi_sdo_oe), 16'h0);
    endtask

    task automatic write_one(input string tag, input logic [5:0] addr, input logic [7:0] data);
        logic [7:0] rx;
        logic oe_any, oe_all;
        if (!((addr == 6'h00) || ((addr >= 6'h32) && (addr <= 6'h37))))
            exp_wr.push_back({addr, data});
        cs_begin();
        send_cmd(tag, {2'b00, addr});
        xfer_bits(data, 8, rx, oe_any, oe_all);
        check({tag, "_data_oe"}, 16'(oe_any), 16'h0);
        cs_end();
    endtask

    task automatic check_writes(input string tag);
        check({tag, "_wr_count"}, 16'(wr_log.size()), 16'(exp_wr.size()));
        while (wr_log.size() > 0 && exp_wr.size() > 0)
            check({tag, "_wr_addr_data"}, 16'(wr_log.pop_front()), 16'(exp_wr.pop_front()));
        wr_log.delete();
        exp_wr.delete();
    endtask

    task automatic pulse_sample(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
        smp_x = x;
        smp_y = y;
        smp_z = z;
        smp_valid = 1'b1;
        tick(1);
        smp_valid = 1'b0;
        tick(1);
    endtask

    initial begin
        logic [7:0] rx;
        logic oe_any, oe_all;

        // Outputs while reset is held
        tick(3);
        check("rst_sdo", 16'(spi_sdo), 16'h0);
        check("rst_oe", 16'(spi_sdo_oe), 16'h0);
        check("rst_wr", 16'(reg_wr), 16'h0);
        check("rst_wr_addr", 16'(reg_wr_addr), 16'h0);
        check("rst_wr_data", 16'(reg_wr_data), 16'h0);
        reset_reset_n = 1'b1;
        tick(5);

        // Device ID, single byte
        exp_rd.push_back(8'hE5);
        read_burst("devid", 8'h80, 1);

        // Sample capture in idle, then multi-byte read of all axes
        pulse_sample(16'h1234, 16'hABCD, 16'h8001);
        tick(4);
        exp_rd.push_back(8'h34); exp_rd.push_back(8'h12);
        exp_rd.push_back(8'hCD); exp_rd.push_back(8'hAB);
        exp_rd.push_back(8'h01); exp_rd.push_back(8'h80);
        read_burst("axes", 8'hF2, 6);

        // Plain write and readback
        write_one("wr2d", 6'h2D, 8'h08);
        check_writes("wr2d");
        exp_rd.push_back(8'h08);
        read_burst("rd2d", 8'hAD, 1);

        // Write to a sample register is ignored
        write_one("wr32", 6'h32, 8'hFF);
        check_writes("wr32");
        exp_rd.push_back(8'h34);
        read_burst("rd32", 8'hB2, 1);

        // New sample mid-burst stays pending until cs_n rises
        cs_begin();
        send_cmd("coh", 8'hF2);
        exp_rd.push_back(8'h34); exp_rd.push_back(8'h12);
        exp_rd.push_back(8'hCD); exp_rd.push_back(8'hAB);
        exp_rd.push_back(8'h01); exp_rd.push_back(8'h80);
        for (int b = 0; b < 6; b++) begin
            if (b == 2) pulse_sample(16'h5566, 16'h7788, 16'h99AA);
            xfer_bits(8'h00, 8, rx, oe_any, oe_all);
            check($sformatf("coh_b%0d", b), 16'(rx), 16'(exp_rd.pop_front()));
        end
        cs_end();
        exp_rd.push_back(8'h66); exp_rd.push_back(8'h55);
        exp_rd.push_back(8'h88); exp_rd.push_back(8'h77);
        exp_rd.push_back(8'hAA); exp_rd.push_back(8'h99);
        read_burst("newsmp", 8'hF2, 6);

        // Aborted write leaves 0x3F untouched; MB read wraps to DEVID
        write_one("wr3f", 6'h3F, 8'h5A);
        check_writes("wr3f");
        cs_begin();
        send_cmd("abort", 8'h3F);
        xfer_bits(8'hFF, 4, rx, oe_any, oe_all);
        cs_end();
        check("abort_oe", 16'(spi_sdo_oe), 16'h0);
        check_writes("abort");
        exp_rd.push_back(8'h5A);
        exp_rd.push_back(8'hE5);
        read_burst("wrap", 8'hFF, 2);

        // Reset mid-transaction: no fresh cs_n fall, so the following bytes are ignored
        cs_begin();
        xfer_bits(8'h2D, 3, rx, oe_any, oe_all);
        reset_reset_n = 1'b0;
        tick(2);
        check("midrst_oe", 16'(spi_sdo_oe), 16'h0);
        reset_reset_n = 1'b1;
        tick(4);
        xfer_bits(8'h2D, 8, rx, oe_any, oe_all);
        xfer_bits(8'h77, 8, rx, oe_any, oe_all);
        check("midrst_no_oe", 16'(oe_any), 16'h0);
        cs_end();
        check_writes("midrst");
        exp_rd.push_back(8'h00);
        read_burst("post_rst", 8'hAD, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
